// File: rtl/escalonador_rr_pkg.sv
// Shared types and constants for the escalonador_rr round-robin scheduler.
// Contents: scheduler state enum, SO process id, context index width.
package escalonador_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SELECT,
        RESTORE,
        RUN,
        SAVE,
        DONE
    } state_e;

    localparam int unsigned ID_SO     = 0;
    localparam int unsigned CTX_IDX_W = 5;

endpackage

// File: rtl/escalonador_rr_if.sv
// Handshake/bus bundle between the SO/CPU side and the escalonador_rr scheduler.
//  master : environment side (drives start, proc_valid, instr_en, proc_halt, proc_wait, ctx_ack)
//  slave  : scheduler side (drives sel_bios, id_proc, ctx_save, ctx_restore, ctx_idx,
//           quantum_over, all_done, busy)
interface escalonador_rr_if #(
    parameter int unsigned N_PROC = 3,
    parameter int unsigned ID_W   = 2
);
    import escalonador_pkg::*;

    logic                 start;
    logic [N_PROC-1:0]    proc_valid;
    logic                 instr_en;
    logic                 proc_halt;
    logic                 proc_wait;
    logic                 ctx_ack;

    logic                 sel_bios;
    logic [ID_W-1:0]      id_proc;
    logic                 ctx_save;
    logic                 ctx_restore;
    logic [CTX_IDX_W-1:0] ctx_idx;
    logic                 quantum_over;
    logic                 all_done;
    logic                 busy;

    modport master (
        output start, proc_valid, instr_en, proc_halt, proc_wait, ctx_ack,
        input  sel_bios, id_proc, ctx_save, ctx_restore, ctx_idx,
               quantum_over, all_done, busy
    );

    modport slave (
        input  start, proc_valid, instr_en, proc_halt, proc_wait, ctx_ack,
        output sel_bios, id_proc, ctx_save, ctx_restore, ctx_idx,
               quantum_over, all_done, busy
    );

endinterface

// File: rtl/escalonador_rr_quantum_timer.sv
// quantum_timer: counts retired instructions of the running process.
//  clk, rst_n : clock, async active-low reset
//  clear_i    : force count to zero (held while the process is not running)
//  en_i       : one instruction retired
//  freeze_i   : mask the current instruction (not charged to the slice)
//  expire_o   : combinational, high on the instruction that completes the slice
module quantum_timer #(
    parameter int unsigned QUANTUM = 20
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear_i,
    input  logic en_i,
    input  logic freeze_i,
    output logic expire_o
);

    localparam int unsigned CNT_W = (QUANTUM > 1) ? $clog2(QUANTUM) : 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             step;

    assign step     = en_i && !freeze_i;
    assign expire_o = step && (cnt_q == CNT_W'(QUANTUM - 1));

    // Next count: wraps to zero on expiry since the slice ends there anyway
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (step) begin
            cnt_d = expire_o ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/escalonador_rr.sv
// escalonador_rr: round-robin scheduler handing the CPU from the SO (id 0) to
// user processes 1..N_PROC, with per-word context save/restore sequencing.
//  clk   : system clock
//  reset : asynchronous, active-low reset
//  bus   : escalonador_rr_if.slave (start/proc_valid/instr_en/proc_halt/proc_wait/ctx_ack in;
//          sel_bios/id_proc/ctx_save/ctx_restore/ctx_idx/quantum_over/all_done/busy out)
// Build option: QUANTUM_WAIT_FREEZE_EN -- when defined, instructions retired while
// proc_wait=1 are not charged to the quantum.
module escalonador_rr
    import escalonador_pkg::*;
#(
    parameter int unsigned N_PROC   = 3,
    parameter int unsigned ID_W     = 2,
    parameter int unsigned QUANTUM  = 20,
    parameter int unsigned CTX_REGS = 32
) (
    input  logic              clk,
    input  logic              reset,
    escalonador_rr_if.slave   bus
);

    state_e               state_q, state_d;
    logic [N_PROC-1:0]    runnable_q, runnable_d;
    logic [N_PROC-1:0]    finished_q, finished_d;
    logic [ID_W-1:0]      last_id_q, last_id_d;
    logic [ID_W-1:0]      id_q, id_d;
    logic [CTX_IDX_W-1:0] ctx_idx_q, ctx_idx_d;
    logic                 sel_bios_q, ctx_save_q, ctx_restore_q, all_done_q, busy_q;
    logic                 quantum_over_c;
    logic                 expire;
    logic                 freeze;
    logic                 last_word;
    logic [ID_W-1:0]      pick;

    // First available id after 'last', wrapping N_PROC -> 1; ID_SO when none
    function automatic logic [ID_W-1:0] pick_next(input logic [N_PROC-1:0] avail,
                                                  input logic [ID_W-1:0]   last);
        logic [ID_W-1:0]   res;
        logic [N_PROC-1:0] sh;
        int unsigned       cand;
        res = ID_W'(ID_SO);
        for (int unsigned k = 1; k <= N_PROC; k++) begin
            cand = (32'(last) + k - 1) % N_PROC;
            sh   = avail >> cand;
            if (res == ID_W'(ID_SO) && sh[0]) begin
                res = ID_W'(cand + 1);
            end
        end
        return res;
    endfunction

`ifdef QUANTUM_WAIT_FREEZE_EN
    assign freeze = bus.proc_wait;
`else
    logic unused_wait;
    assign freeze      = 1'b0;
    assign unused_wait = bus.proc_wait;
`endif

    quantum_timer #(
        .QUANTUM (QUANTUM)
    ) u_timer (
        .clk      (clk),
        .rst_n    (reset),
        .clear_i  (state_q != RUN),
        .en_i     ((state_q == RUN) && bus.instr_en),
        .freeze_i (freeze),
        .expire_o (expire)
    );

    assign last_word = (ctx_idx_q == CTX_IDX_W'(CTX_REGS - 1));
    assign pick      = pick_next(runnable_q & ~finished_q, last_id_q);

    // Next-state and datapath decisions
    always_comb begin
        state_d        = state_q;
        runnable_d     = runnable_q;
        finished_d     = finished_q;
        last_id_d      = last_id_q;
        id_d           = id_q;
        ctx_idx_d      = ctx_idx_q;
        quantum_over_c = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    runnable_d = bus.proc_valid;
                    finished_d = '0;
                    state_d    = SELECT;
                end
            end
            SELECT: begin
                ctx_idx_d = '0;
                if (pick == ID_W'(ID_SO)) begin
                    id_d    = ID_W'(ID_SO);
                    state_d = DONE;
                end else begin
                    id_d      = pick;
                    last_id_d = pick;
                    state_d   = RESTORE;
                end
            end
            RESTORE: begin
                if (bus.ctx_ack) begin
                    if (last_word) begin
                        ctx_idx_d = '0;
                        state_d   = RUN;
                    end else begin
                        ctx_idx_d = ctx_idx_q + CTX_IDX_W'(1);
                    end
                end
            end
            RUN: begin
                // Halt takes priority over a coinciding expiry: no pulse, no save
                if (bus.proc_halt) begin
                    finished_d = finished_q | (N_PROC'(1) << (id_q - ID_W'(1)));
                    state_d    = SELECT;
                end else if (expire) begin
                    quantum_over_c = 1'b1;
                    ctx_idx_d      = '0;
                    state_d        = SAVE;
                end
            end
            SAVE: begin
                if (bus.ctx_ack) begin
                    if (last_word) begin
                        ctx_idx_d = '0;
                        state_d   = SELECT;
                    end else begin
                        ctx_idx_d = ctx_idx_q + CTX_IDX_W'(1);
                    end
                end
            end
            DONE: begin
                if (bus.start) begin
                    runnable_d = bus.proc_valid;
                    finished_d = '0;
                    state_d    = SELECT;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, bookkeeping and output registers; outputs follow the next state
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            runnable_q    <= '0;
            finished_q    <= '0;
            last_id_q     <= ID_W'(N_PROC);
            id_q          <= ID_W'(ID_SO);
            ctx_idx_q     <= '0;
            sel_bios_q    <= 1'b1;
            ctx_save_q    <= 1'b0;
            ctx_restore_q <= 1'b0;
            all_done_q    <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            runnable_q    <= runnable_d;
            finished_q    <= finished_d;
            last_id_q     <= last_id_d;
            id_q          <= id_d;
            ctx_idx_q     <= ctx_idx_d;
            sel_bios_q    <= (state_d != RUN);
            ctx_save_q    <= (state_d == SAVE);
            ctx_restore_q <= (state_d == RESTORE);
            all_done_q    <= (state_d == DONE);
            busy_q        <= (state_d != IDLE) && (state_d != DONE);
        end
    end

    assign bus.sel_bios     = sel_bios_q;
    assign bus.id_proc      = id_q;
    assign bus.ctx_save     = ctx_save_q;
    assign bus.ctx_restore  = ctx_restore_q;
    assign bus.ctx_idx      = ctx_idx_q;
    assign bus.quantum_over = quantum_over_c;
    assign bus.all_done     = all_done_q;
    assign bus.busy         = busy_q;

endmodule

// File: tb/tb_escalonador_rr.sv
// Self-checking bench for escalonador_rr: a driver issues sessions and pushes the
// expected scheduling events; a monitor pops them as the DUT presents them.
module tb_escalonador_rr;
    import escalonador_pkg::*;

    localparam int N_PROC   = 3;
    localparam int ID_W     = 2;
    localparam int QUANTUM  = 20;
    localparam int CTX_REGS = 32;
    localparam int MAX_WAIT = 4000;

    localparam int EV_RESTORE = 0;
    localparam int EV_SAVE    = 1;
    localparam int EV_QOVER   = 2;
    localparam int EV_DONE    = 3;

`ifdef QUANTUM_WAIT_FREEZE_EN
    localparam bit FREEZE = 1'b1;
`else
    localparam bit FREEZE = 1'b0;
`endif

    typedef struct {
        int kind;
        int id;
    } ev_t;

    logic clk = 1'b0;
    logic rst_n;
    ev_t  exp_q[$];
    int   plan_q[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    // Reference model: bitmasks of runnable/finished ids and the last id served
    int m_run;
    int m_fin;
    int m_last;

    escalonador_rr_if #(.N_PROC(N_PROC), .ID_W(ID_W)) bus ();

    escalonador_rr #(
        .N_PROC   (N_PROC),
        .ID_W     (ID_W),
        .QUANTUM  (QUANTUM),
        .CTX_REGS (CTX_REGS)
    ) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    initial forever #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void push_ev(input int kind, input int id);
        ev_t e;
        e.kind = kind;
        e.id   = id;
        exp_q.push_back(e);
    endfunction

    function automatic void model_reset();
        m_run  = 0;
        m_fin  = 0;
        m_last = N_PROC;
    endfunction

    // Walk ids after the last one served, wrapping, and take the first still eligible
    function automatic int model_pick();
        for (int k = 1; k <= N_PROC; k++) begin
            int id;
            id = (m_last + k - 1) % N_PROC + 1;
            if (((m_run >> (id - 1)) & 1) != 0 && ((m_fin >> (id - 1)) & 1) == 0) begin
                return id;
            end
        end
        return 0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_sel_bios"},     int'(bus.sel_bios), 1);
        chk({tag, "_id_proc"},      int'(bus.id_proc), 0);
        chk({tag, "_ctx_save"},     int'(bus.ctx_save), 0);
        chk({tag, "_ctx_restore"},  int'(bus.ctx_restore), 0);
        chk({tag, "_ctx_idx"},      int'(bus.ctx_idx), 0);
        chk({tag, "_quantum_over"}, int'(bus.quantum_over), 0);
        chk({tag, "_all_done"},     int'(bus.all_done), 0);
        chk({tag, "_busy"},         int'(bus.busy), 0);
    endtask

    task automatic do_reset();
        tick();
        rst_n = 1'b0;
        model_reset();
        exp_q.delete();
        @(negedge clk);
        check_reset_outputs("reset");
        tick();
        rst_n = 1'b1;
    endtask

    task automatic do_start(input logic [N_PROC-1:0] v);
        tick();
        bus.start      = 1'b1;
        bus.proc_valid = v;
        m_run          = int'(v);
        m_fin          = 0;
        tick();
        bus.start      = 1'b0;
        bus.proc_valid = N_PROC'($urandom);
    endtask

    // One time slice of process 'id'; halt_at = instruction number that halts (0 = never)
    task automatic run_slot(input int id, input int halt_at, input bit use_wait, output bit ok);
        int cnt, issued, rcyc, w0, cyc;
        bit ins, wt, cnts, fin;
        cnt = 0; issued = 0; rcyc = 0; cyc = 0; fin = 1'b0; ok = 1'b1;
        while (bus.sel_bios !== 1'b0 && cyc < MAX_WAIT) begin
            @(negedge clk);
            cyc++;
        end
        chk("run_entry_in_time", int'(cyc < MAX_WAIT), 1);
        if (cyc >= MAX_WAIT) begin
            ok = 1'b0;
            return;
        end
        w0 = $urandom_range(0, 12);
        while (!fin) begin
            tick();
            ins  = ($urandom_range(0, 2) != 0);
            wt   = use_wait && (rcyc >= w0) && (rcyc < w0 + 10);
            cnts = ins && !(FREEZE && wt);
            bus.instr_en   = ins;
            bus.proc_wait  = wt;
            bus.proc_halt  = 1'b0;
            bus.start      = ($urandom_range(0, 15) == 0);
            bus.proc_valid = N_PROC'($urandom);
            if (ins) issued++;
            if (ins && halt_at != 0 && issued == halt_at) begin
                bus.proc_halt = 1'b1;
                m_fin = m_fin | (1 << (id - 1));
                fin   = 1'b1;
            end else if (cnts && cnt + 1 == QUANTUM) begin
                push_ev(EV_QOVER, id);
                push_ev(EV_SAVE, id);
                fin = 1'b1;
            end
            if (cnts) cnt++;
            rcyc++;
            if (!fin && rcyc > MAX_WAIT) begin
                n_chk++;
                n_fail++;
                $display("FAIL run_exit_in_time: slot of id %0d still running after %0d cycles", id, rcyc);
                ok  = 1'b0;
                fin = 1'b1;
            end
        end
        tick();
        bus.instr_en  = 1'b0;
        bus.proc_halt = 1'b0;
        bus.proc_wait = 1'b0;
        bus.start     = 1'b0;
    endtask

    task automatic run_session(input logic [N_PROC-1:0] v, input bit use_wait);
        int id, halt_at, cyc, slots;
        bit ok;
        do_start(v);
        slots = 0;
        forever begin
            id = model_pick();
            if (id == 0) begin
                push_ev(EV_DONE, 0);
                cyc = 0;
                while (bus.all_done !== 1'b1 && cyc < MAX_WAIT) begin
                    @(negedge clk);
                    cyc++;
                end
                chk("done_in_time", int'(cyc < MAX_WAIT), 1);
                break;
            end
            push_ev(EV_RESTORE, id);
            m_last  = id;
            halt_at = (plan_q.size() > 0) ? plan_q.pop_front() : $urandom_range(1, QUANTUM);
            run_slot(id, halt_at, use_wait, ok);
            slots++;
            if (!ok || slots > 20) break;
        end
        plan_q.delete();
    endtask

    // Background register-bank acknowledge with random gaps
    initial begin
        bus.ctx_ack = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            bus.ctx_ack = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic pop_check(input int kind, input int id);
        ev_t e;
        if (exp_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_event: kind %0d id %0d seen, none expected (t=%0t)", kind, id, $time);
        end else begin
            e = exp_q.pop_front();
            chk("event_kind", kind, e.kind);
            chk("event_id", id, e.id);
        end
    endtask

    // Monitor: pops an expectation for every event the DUT presents
    initial begin
        bit prev_x, prev_done, xfer;
        int exp_idx;
        prev_x = 1'b0; prev_done = 1'b0; exp_idx = 0;
        forever begin
            @(negedge clk);
            if (rst_n !== 1'b1) begin
                prev_x    = 1'b0;
                prev_done = 1'b0;
                continue;
            end
            xfer = bus.ctx_save || bus.ctx_restore;
            chk("save_restore_exclusive", int'(bus.ctx_save && bus.ctx_restore), 0);
            if (xfer && !prev_x) begin
                exp_idx = 0;
                pop_check(bus.ctx_save ? EV_SAVE : EV_RESTORE, int'(bus.id_proc));
            end
            if (xfer) begin
                chk("ctx_idx", int'(bus.ctx_idx), exp_idx);
                chk("sel_bios_in_xfer", int'(bus.sel_bios), 1);
                if (bus.ctx_ack) exp_idx++;
            end
            if (!xfer && prev_x) begin
                chk("xfer_words", exp_idx, CTX_REGS);
            end
            if (bus.quantum_over) begin
                pop_check(EV_QOVER, int'(bus.id_proc));
            end
            if (bus.all_done && !prev_done) begin
                pop_check(EV_DONE, 0);
                chk("done_sel_bios", int'(bus.sel_bios), 1);
                chk("done_id_proc", int'(bus.id_proc), 0);
                chk("done_busy", int'(bus.busy), 0);
            end
            prev_x    = xfer;
            prev_done = bus.all_done;
        end
    end

    initial begin
        int cyc;
        rst_n          = 1'b0;
        bus.start      = 1'b0;
        bus.proc_valid = '0;
        bus.instr_en   = 1'b0;
        bus.proc_halt  = 1'b0;
        bus.proc_wait  = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("por");
        tick();
        rst_n = 1'b1;

        // Full quanta on all three: restores 1,2,3,1
        plan_q = '{0, 0, 0, 0};
        run_session(3'b111, 1'b0);

        // Only 1 and 3 runnable: 1,3,1
        do_reset();
        plan_q = '{0, 0, 0};
        run_session(3'b101, 1'b0);

        // Id 2 halts on its 5th instruction: next restore is id 3, no save
        do_reset();
        plan_q = '{0, 5};
        run_session(3'b111, 1'b0);

        // Halt coincides with the expiring instruction: halt wins
        do_reset();
        plan_q = '{QUANTUM, 0};
        run_session(3'b111, 1'b0);

        // Blocked-on-input windows during RUN
        do_reset();
        plan_q = '{0, 0, 0};
        run_session(3'b111, 1'b1);

        // Nothing runnable: SELECT then DONE
        do_reset();
        do_start(3'b000);
        push_ev(EV_DONE, 0);
        @(negedge clk);
        chk("empty_select_busy", int'(bus.busy), 1);
        @(negedge clk);
        chk("empty_done", int'(bus.all_done), 1);

        // Single runnable process: expiry still saves then restores the same id
        plan_q = '{0, 0};
        run_session(3'b010, 1'b0);

        // Reset in the middle of a SAVE, then restart from id 1
        do_reset();
        do_start(3'b111);
        begin
            bit ok;
            int id;
            id = model_pick();
            push_ev(EV_RESTORE, id);
            m_last = id;
            run_slot(id, 0, 1'b0, ok);
        end
        cyc = 0;
        while (!(bus.ctx_save === 1'b1 && bus.ctx_idx == 5'd7) && cyc < MAX_WAIT) begin
            @(negedge clk);
            cyc++;
        end
        chk("save_idx7_reached", int'(cyc < MAX_WAIT), 1);
        #2;
        rst_n = 1'b0;
        @(negedge clk);
        check_reset_outputs("mid_save");
        chk("queue_empty_at_abort", exp_q.size(), 0);
        model_reset();
        exp_q.delete();
        tick();
        rst_n = 1'b1;
        plan_q = '{0};
        run_session(3'b111, 1'b0);

        // Random sessions chained through DONE -> start
        for (int s = 0; s < 6; s++) begin
            int np;
            np = $urandom_range(0, 3);
            for (int p = 0; p < np; p++) begin
                plan_q.push_back(($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, QUANTUM));
            end
            run_session(N_PROC'($urandom), 1'($urandom_range(0, 1)));
        end

        repeat (5) @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
